// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the step sequencer.
// step_t        : one-hot step codes, also the value driven on the step output
// DONE_BLANK_CLKS : clks after entering STEP_4 during which done2 is ignored
// max4          : elaboration-time helper used to size the dwell counter
package vga_seq_pkg;

  typedef enum logic [3:0] {
    STEP_IDLE = 4'b0000,
    STEP_1    = 4'b0001,
    STEP_2    = 4'b0010,
    STEP_3    = 4'b0100,
    STEP_4    = 4'b1000
  } step_t;

  // The downstream done path has two register stages, so a pulse left over
  // from the previous round can still arrive during the first two clks.
  localparam int DONE_BLANK_CLKS = 2;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the step sequencer and its surroundings.
// start, abort, done2 : requests into the sequencer
// step                : current one-hot step code
// tick                : one-clk prescaled tick while busy
// busy                : sequencer is outside IDLE
// timeout_err         : sticky step-4 timeout flag
// rounds              : saturating count of rounds closed by done2
// Modports: master drives the requests, slave is the sequencer itself.
interface step_sequencer_if;
  import vga_seq_pkg::*;

  logic       start;
  logic       abort;
  logic       done2;
  step_t      step;
  logic       tick;
  logic       busy;
  logic       timeout_err;
  logic [7:0] rounds;

  modport master (
    output start, abort, done2,
    input  step, tick, busy, timeout_err, rounds
  );

  modport slave (
    input  start, abort, done2,
    output step, tick, busy, timeout_err, rounds
  );

endinterface

// File: rtl/step_sequencer_tick_prescaler.sv
// Free-running clk divider that produces the sequencer time base.
// clk, rst : clock and asynchronous active-high reset
// en       : count while high, hold at zero while low
// clr      : synchronous restart of the count from zero
// tick     : high for the single clk in which the count is TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  // Clearing on clr lets every new step start a full tick period, so a
  // timed step lasts exactly N*TICK_DIV clks regardless of entry phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Four-step control sequencer that drives the per-step cronometer blocks.
// Steps 1-3 dwell a fixed number of prescaled ticks; step 4 waits for done2
// from the step-4 cronometer or gives up after TIMEOUT_TICKS ticks.
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of step_sequencer_if (start/abort/done2 in;
//            step/tick/busy/timeout_err/rounds out)
module step_sequencer
  import vga_seq_pkg::*;
#(
  parameter int TICK_DIV      = 50000000,
  parameter int STEP1_TICKS   = 3,
  parameter int STEP2_TICKS   = 5,
  parameter int STEP3_TICKS   = 2,
  parameter int TIMEOUT_TICKS = 8
) (
  input logic            clk,
  input logic            rst,
  step_sequencer_if.slave bus
);

  localparam int MAX_TICKS = max4(STEP1_TICKS, STEP2_TICKS, STEP3_TICKS, TIMEOUT_TICKS);
  localparam int DWELL_W   = $clog2(MAX_TICKS) + 1;
  localparam int BLANK_W   = $clog2(DONE_BLANK_CLKS + 1);

  localparam logic [DWELL_W-1:0] LAST1   = DWELL_W'(STEP1_TICKS - 1);
  localparam logic [DWELL_W-1:0] LAST2   = DWELL_W'(STEP2_TICKS - 1);
  localparam logic [DWELL_W-1:0] LAST3   = DWELL_W'(STEP3_TICKS - 1);
  localparam logic [DWELL_W-1:0] LAST_TO = DWELL_W'(TIMEOUT_TICKS - 1);
  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(DONE_BLANK_CLKS);

  step_t              state;
  step_t              state_nxt;
  logic [DWELL_W-1:0] dwell;
  logic [BLANK_W-1:0] blank;
  logic               busy;
  logic               timeout_err;
  logic [7:0]         rounds;
  logic               tick;
  logic               done_ok;
  logic               timed_out;
  logic               rounds_inc;
  logic               state_change;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (state_change),
    .tick (tick)
  );

  // Next-state decision. abort overrides everything; in step 4 an accepted
  // done2 beats a timeout tick arriving in the same clk.
  always_comb begin
    state_nxt  = state;
    timed_out  = 1'b0;
    done_ok    = (state == STEP_4) && bus.done2 && (blank == '0);
    rounds_inc = 1'b0;
    if (bus.abort) begin
      state_nxt = STEP_IDLE;
    end else begin
      case (state)
        STEP_IDLE: if (bus.start) state_nxt = STEP_1;
        STEP_1:    if (tick && dwell == LAST1) state_nxt = STEP_2;
        STEP_2:    if (tick && dwell == LAST2) state_nxt = STEP_3;
        STEP_3:    if (tick && dwell == LAST3) state_nxt = STEP_4;
        STEP_4: begin
          if (done_ok) begin
            state_nxt  = STEP_1;
            rounds_inc = 1'b1;
          end else if (tick && dwell == LAST_TO) begin
            state_nxt = STEP_IDLE;
            timed_out = 1'b1;
          end
        end
        default:   state_nxt = STEP_IDLE;
      endcase
    end
  end

  assign state_change = (state_nxt != state);

  // State, dwell/blank bookkeeping and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STEP_IDLE;
      dwell       <= '0;
      blank       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rounds      <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != STEP_IDLE);

      if (state_change) begin
        dwell <= '0;
      end else if (tick) begin
        dwell <= dwell + 1'b1;
      end

      // blank reaches zero on the third clk in step 4, opening done2.
      if (state_change && state_nxt == STEP_4) begin
        blank <= BLANK_INIT;
      end else if (blank != '0) begin
        blank <= blank - 1'b1;
      end

      if (!bus.abort) begin
        if (state == STEP_IDLE && bus.start) begin
          timeout_err <= 1'b0;
        end else if (timed_out) begin
          timeout_err <= 1'b1;
        end
      end

      if (rounds_inc && rounds != 8'hFF) begin
        rounds <= rounds + 1'b1;
      end
    end
  end

  assign bus.step        = state;
  assign bus.tick        = tick;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;
  assign bus.rounds      = rounds;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with a 4-clk tick.
// Expected output vectors are queued as each clk of stimulus is driven and
// popped once the DUT has settled after the following rising edge.
module tb_step_sequencer;
  import vga_seq_pkg::*;

  localparam int TD  = 4;
  localparam int S1T = 3;
  localparam int S2T = 5;
  localparam int S3T = 2;
  localparam int TOT = 8;

  // Cycle indices counted from the clk in which start (or done2) is presented.
  localparam int S1_END  = 1 + S1T * TD;
  localparam int S2_END  = S1_END + S2T * TD;
  localparam int S4_IN   = S2_END + S3T * TD;
  localparam int TO_LAST = S4_IN + TOT * TD - 1;

  logic clk;
  logic rst;

  step_sequencer_if sif ();

  step_sequencer #(
    .TICK_DIV      (TD),
    .STEP1_TICKS   (S1T),
    .STEP2_TICKS   (S2T),
    .STEP3_TICKS   (S3T),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          exp_rounds = 0;
  logic        exp_err = 1'b0;
  logic [14:0] want;
  string       tag;
  logic [14:0] observed;

  assign observed = {sif.step, sif.tick, sif.busy, sif.timeout_err, sif.rounds};

  function automatic string fmt(input logic [14:0] v);
    return $sformatf("step=%b tick=%b busy=%b err=%b rounds=%0d",
                     v[14:11], v[10], v[9], v[8], v[7:0]);
  endfunction

  function automatic logic [3:0] walk_step(input int c);
    if (c < S1_END) return 4'b0001;
    if (c < S2_END) return 4'b0010;
    if (c < S4_IN)  return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic walk_tick(input int c);
    return (c % TD) == 0;
  endfunction

  function automatic int sat_inc(input int r);
    return (r < 255) ? r + 1 : 255;
  endfunction

  task automatic tick_clk(input logic s, input logic a, input logic d);
    sif.start = s;
    sif.abort = a;
    sif.done2 = d;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.done2 = 1'b0;
  endtask

  task automatic drive(input logic s, input logic a, input logic d,
                       input logic [3:0] es, input logic et, input string t);
    exp_q.push_back({es, et, (es != 4'b0000), exp_err, exp_rounds[7:0]});
    tag_q.push_back(t);
    tick_clk(s, a, d);
  endtask

  task automatic go_idle();
    tick_clk(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(15'd0);
    tag_q.push_back("reset state");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "idle after reset");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
  endtask

  // start held for several clks (ignored once busy) and a stray done2 in S2.
  task automatic test_walk();
    go_idle();
    for (int c = 1; c <= 45; c++) begin
      drive(c <= 6, 1'b0, c == 20, walk_step(c), walk_tick(c), $sformatf("walk c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  task automatic test_done2();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    repeat (S4_IN + 3) tick_clk(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b1000, walk_tick(S4_IN + 5), "S4 before done2");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    exp_rounds = sat_inc(exp_rounds);
    for (int c = 1; c <= 13; c++) begin
      drive(1'b0, 1'b0, c == 1, walk_step(c), walk_tick(c), $sformatf("after done2 c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  // done2 held from the S4 entry clk: rejected twice, taken on the third clk.
  task automatic test_blank_edge();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    repeat (S4_IN - 1) tick_clk(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) exp_rounds = sat_inc(exp_rounds);
      drive(1'b0, 1'b0, 1'b1, (k == 2) ? 4'b0001 : 4'b1000, 1'b0, $sformatf("blank edge k=%0d", k));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  task automatic test_timeout();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    repeat (S4_IN - 1) tick_clk(1'b0, 1'b0, 1'b0);
    for (int c = S4_IN + 1; c <= TO_LAST + 4; c++) begin
      if (c == TO_LAST + 1) exp_err = 1'b1;
      drive(1'b0, c == TO_LAST + 3, c == S4_IN + 2,
            (c <= TO_LAST) ? 4'b1000 : 4'b0000,
            (c <= TO_LAST) ? walk_tick(c) : 1'b0, $sformatf("timeout c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
    exp_err = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      drive(c == 1, 1'b0, 1'b0, walk_step(c), walk_tick(c), $sformatf("restart c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  task automatic test_abort();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    repeat (15) tick_clk(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(k == 7, k == 0 || k == 7, 1'b0, 4'b0000, 1'b0, $sformatf("abort k=%0d", k));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
    for (int c = 1; c <= 14; c++) begin
      drive(c == 1, 1'b0, 1'b0, walk_step(c), walk_tick(c), $sformatf("rewalk c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  task automatic test_coincident();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    repeat (TO_LAST - 2) tick_clk(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, "timeout tick clk");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    exp_rounds = sat_inc(exp_rounds);
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, 1'b0, c == 1, walk_step(c), walk_tick(c), $sformatf("coincident c=%0d", c));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
  endtask

  task automatic test_saturation_and_reset();
    go_idle();
    tick_clk(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      repeat (S4_IN + 1) tick_clk(1'b0, 1'b0, 1'b0);
      exp_rounds = sat_inc(exp_rounds);
      drive(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, $sformatf("round %0d", i));
      want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    end
    repeat (S2_END) tick_clk(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b0100, walk_tick(S2_END + 2), "mid S3");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    #2;
    rst = 1'b1;
    #1;
    exp_rounds = 0;
    exp_err = 1'b0;
    exp_q.push_back(15'd0);
    tag_q.push_back("async reset mid S3");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "no resume after reset");
    want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
    if (observed !== want) begin failures++; $display("[TB] FAIL %s: got %s, required %s", tag, fmt(observed), fmt(want)); end
  endtask

  initial begin
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.done2 = 1'b0;
    rst = 1'b1;
    test_reset();
    test_walk();
    test_done2();
    test_blank_edge();
    test_timeout();
    test_abort();
    test_coincident();
    test_saturation_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
